re_normalizer_pipe: RTL and testbench

- Parametrised, pipelined leading-one normaliser for the log-domain datapath.
- Converts an unsigned integer operand into an exponent k (index of the leading one) and an M1_W-bit fraction m1 (the bits immediately below the leading one).
- Adds the following on top of the combinational 32-bit shifter:
  - configurable operand and fraction widths;
  - selectable truncate or round-to-nearest-even (RNE);
  - zero and saturation flags;
  - a 3-stage elastic valid/ready pipeline.
- Sits between the operand registers and the log adder.

---
 rtl/re_normalizer_pipe.sv | 149 ++++++++++++++
 tb/tb_re_normalizer_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/re_normalizer_pipe.sv
// Pipelined leading-one normaliser: splits an unsigned operand into exponent k
// and an M1_W-bit fraction, with optional round-to-nearest-even and saturation.
module re_normalizer_pipe #(
    parameter int NUM_W = 32,
    parameter int M1_W  = 8,
    parameter int K_W   = $clog2(NUM_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] in_num,
    input  logic             in_round,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K_W-1:0]   out_k,
    output logic [M1_W-1:0]  out_m1,
    output logic             out_zero,
    output logic             out_sat
);

    // The shifted value gets one extra zero bit below bit 0, so the guard bit
    // always exists even when the fraction reaches all the way down to bit 0.
    localparam int GI = NUM_W - 1 - M1_W;
    localparam logic [NUM_W:0] LOW_MASK = ((NUM_W+1)'(1) << GI) - (NUM_W+1)'(1);
    localparam logic [K_W-1:0] K_MAX = '1;

    logic ld1, ld2, ld3;
    logic v1, v2;

    logic [NUM_W-1:0] num1;
    logic [K_W-1:0]   k1;
    logic             round1, zero1;

    logic [K_W-1:0]   k2;
    logic [M1_W-1:0]  frac2;
    logic             guard2, sticky2, round2, zero2;

    logic [K_W-1:0]   lead_k;
    logic [K_W-1:0]   shamt;
    logic [NUM_W-1:0] shifted;
    logic [NUM_W:0]   ext;
    logic             inc;
    logic [M1_W:0]    sum;

    assign ld3      = !out_valid || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    always_comb begin
        lead_k = '0;
        for (int i = 0; i < NUM_W; i++) begin
            if (in_num[i]) lead_k = K_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            num1   <= '0;
            k1     <= '0;
            round1 <= 1'b0;
            zero1  <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld1 && in_valid) begin
                num1   <= in_num;
                k1     <= lead_k;
                round1 <= in_round;
                zero1  <= (in_num == '0);
            end
        end
    end

    // NUM_W is a power of two, so NUM_W-1-k is simply the bitwise inverse of k.
    assign shamt = ~k1;

    always_comb begin
        shifted = num1;
        for (int b = K_W - 1; b >= 0; b--) begin
            if (shamt[b]) shifted = shifted << (1 << b);
        end
    end

    assign ext = {shifted, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            k2      <= '0;
            frac2   <= '0;
            guard2  <= 1'b0;
            sticky2 <= 1'b0;
            round2  <= 1'b0;
            zero2   <= 1'b0;
        end else begin
            if (ld2) v2 <= v1;
            if (ld2 && v1) begin
                k2      <= k1;
                frac2   <= ext[NUM_W-1 -: M1_W];
                guard2  <= ext[GI];
                sticky2 <= |(ext & LOW_MASK);
                round2  <= round1;
                zero2   <= zero1;
            end
        end
    end

    assign inc = round2 && guard2 && (sticky2 || frac2[0]);
    assign sum = {1'b0, frac2} + {{M1_W{1'b0}}, inc};

    // A carry out of the fraction bumps the exponent, unless it is already at
    // the top, in which case the result pins to the largest representable value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_k     <= '0;
            out_m1    <= '0;
            out_zero  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (ld3) out_valid <= v2;
            if (ld3 && v2) begin
                out_zero <= zero2;
                if (zero2) begin
                    out_k   <= '0;
                    out_m1  <= '0;
                    out_sat <= 1'b0;
                end else if (sum[M1_W]) begin
                    if (k2 == K_MAX) begin
                        out_k   <= K_MAX;
                        out_m1  <= '1;
                        out_sat <= 1'b1;
                    end else begin
                        out_k   <= k2 + 1'b1;
                        out_m1  <= '0;
                        out_sat <= 1'b0;
                    end
                end else begin
                    out_k   <= k2;
                    out_m1  <= sum[M1_W-1:0];
                    out_sat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_re_normalizer_pipe.sv
// Testbench for re_normalizer_pipe: a 32/8 instance driven by a directed table,
// random streams and back-pressure, plus a 16/4 instance swept against a model.
module tb_re_normalizer_pipe;

    typedef struct {
        int k;
        int m1;
        bit z;
        bit s;
    } exp_t;

    typedef struct {
        logic [31:0] num;
        bit          rnd;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_num = '0;
    logic        in_round = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_k;
    logic [7:0]  out_m1;
    logic        out_zero;
    logic        out_sat;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in_num16 = '0;
    logic        in_round16 = 1'b0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [3:0]  out_k16;
    logic [3:0]  out_m1_16;
    logic        out_zero16;
    logic        out_sat16;

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    bit   rand_ready = 1'b0;
    exp_t q32[$];
    exp_t q16[$];

    re_normalizer_pipe #(.NUM_W(32), .M1_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_k(out_k), .out_m1(out_m1), .out_zero(out_zero), .out_sat(out_sat)
    );

    re_normalizer_pipe #(.NUM_W(16), .M1_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_num(in_num16), .in_round(in_round16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_k(out_k16), .out_m1(out_m1_16), .out_zero(out_zero16), .out_sat(out_sat16)
    );

    always #5 clk = ~clk;

    // Occupancy model of the three stages, used to predict in_ready/out_valid.
    logic [2:0] sv;
    logic       sh_ld1, sh_ld2, sh_ld3;
    assign sh_ld3 = !sv[2] || out_ready;
    assign sh_ld2 = !sv[1] || sh_ld3;
    assign sh_ld1 = !sv[0] || sh_ld2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= 3'b000;
        end else begin
            if (sh_ld3) sv[2] <= sv[1];
            if (sh_ld2) sv[1] <= sv[0];
            if (sh_ld1) sv[0] <= in_valid;
        end
    end

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Arithmetic reference: remainder below the leading one, scaled to the fraction.
    function automatic exp_t model(input longint num, input int nw, input int mw, input bit rnd);
        exp_t   e;
        longint rem, frac;
        int     k, d;
        bit     g, st;
        e = '{0, 0, 1'b0, 1'b0};
        if (num == 0) begin
            e.z = 1'b1;
            return e;
        end
        k = 0;
        for (int i = 0; i < nw; i++) if (num >= (longint'(1) << i)) k = i;
        rem = num - (longint'(1) << k);
        d = k - mw;
        g = 1'b0;
        st = 1'b0;
        if (d >= 1) begin
            frac = rem >> d;
            g = ((rem >> (d - 1)) & 1) != 0;
            st = (rem & ((longint'(1) << (d - 1)) - 1)) != 0;
        end else begin
            frac = rem << (-d);
        end
        if (rnd && g && (st || (frac & 1) != 0)) frac++;
        if (frac == (longint'(1) << mw)) begin
            if (k == nw - 1) begin
                e.s = 1'b1;
                frac = (longint'(1) << mw) - 1;
            end else begin
                k++;
                frac = 0;
            end
        end
        e.k = k;
        e.m1 = int'(frac);
        return e;
    endfunction

    task automatic apply_stimulus(input logic [31:0] num, input bit rnd, input exp_t e);
        int n = 0;
        in_num = num;
        in_round = rnd;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("accept_timeout");
        else q32.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_stimulus16(input logic [15:0] num, input bit rnd, input exp_t e);
        int n = 0;
        in_num16 = num;
        in_round16 = rnd;
        in_valid16 = 1'b1;
        @(negedge clk);
        while (!in_ready16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready16) fail_now("accept16_timeout");
        else q16.push_back(e);
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q32.size() != 0 || q16.size() != 0) fail_now("drain_timeout");
        repeat (4) @(negedge clk);
    endtask

    task automatic check_output();
        exp_t e;
        if (out_valid && out_ready) begin
            if (q32.size() == 0) begin
                fail_now("unexpected_out32");
            end else begin
                e = q32.pop_front();
                check("k32", out_k, e.k);
                check("m1_32", out_m1, e.m1);
                check("zero32", out_zero, e.z);
                check("sat32", out_sat, e.s);
            end
        end
        if (out_valid16) begin
            if (q16.size() == 0) begin
                fail_now("unexpected_out16");
            end else begin
                e = q16.pop_front();
                check("k16", out_k16, e.k);
                check("m1_16", out_m1_16, e.m1);
                check("zero16", out_zero16, e.z);
                check("sat16", out_sat16, e.s);
            end
        end
    endtask

    initial begin
        vec_t tbl[12];
        tbl[0]  = '{32'h0000_0001, 1'b0, '{0,  8'h00, 1'b0, 1'b0}};
        tbl[1]  = '{32'h8000_0000, 1'b0, '{31, 8'h00, 1'b0, 1'b0}};
        tbl[2]  = '{32'h0000_01FF, 1'b0, '{8,  8'hFF, 1'b0, 1'b0}};
        tbl[3]  = '{32'h0000_0302, 1'b0, '{9,  8'h81, 1'b0, 1'b0}};
        tbl[4]  = '{32'h0000_0000, 1'b0, '{0,  8'h00, 1'b1, 1'b0}};
        tbl[5]  = '{32'h0000_0302, 1'b1, '{9,  8'h81, 1'b0, 1'b0}};
        tbl[6]  = '{32'h0000_0201, 1'b1, '{9,  8'h00, 1'b0, 1'b0}};
        tbl[7]  = '{32'h0000_03FF, 1'b1, '{10, 8'h00, 1'b0, 1'b0}};
        tbl[8]  = '{32'h0000_03FF, 1'b0, '{9,  8'hFF, 1'b0, 1'b0}};
        tbl[9]  = '{32'hFFFF_FFFF, 1'b1, '{31, 8'hFF, 1'b0, 1'b1}};
        tbl[10] = '{32'hFFFF_FFFF, 1'b0, '{31, 8'hFF, 1'b0, 1'b0}};
        tbl[11] = '{32'h0000_0000, 1'b1, '{0,  8'h00, 1'b1, 1'b0}};

        fork
            begin : main_seq
                logic [31:0] r;
                bit          rb;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("rst_out_valid", out_valid, 0);
                check("rst_in_ready", in_ready, 1);
                check("rst_out_k", out_k, 0);
                check("rst_out_m1", out_m1, 0);
                check("rst_out_zero", out_zero, 0);
                check("rst_out_sat", out_sat, 0);
                @(posedge clk);
                #1;

                // Three operands parked in a stalled pipe, then wiped by reset.
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) apply_stimulus(32'h100 << i, 1'b0, model(32'h100 << i, 32, 8, 1'b0));
                @(negedge clk);
                check("full_in_ready", in_ready, 0);
                @(posedge clk);
                #1 rst_n = 1'b0;
                q32.delete();
                @(negedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                check("midrst_out_valid", out_valid, 0);
                check("midrst_in_ready", in_ready, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
                repeat (10) @(posedge clk);
                #1;

                for (int i = 0; i < 12; i++) apply_stimulus(tbl[i].num, tbl[i].rnd, tbl[i].e);
                drain();
                @(posedge clk);
                #1;

                fork
                    begin
                        for (int i = 0; i < 20; i++) begin
                            r = $urandom >> $urandom_range(0, 31);
                            rb = 1'($urandom_range(0, 1));
                            apply_stimulus(r, rb, model(r, 32, 8, rb));
                        end
                    end
                    begin
                        int lat = 0;
                        @(posedge clk);
                        while (!out_valid && lat < 10) begin
                            @(negedge clk);
                            lat++;
                        end
                        check("latency", lat, 3);
                        for (int i = 0; i < 19; i++) begin
                            @(negedge clk);
                            check("stream_gap", out_valid, 1);
                        end
                    end
                join
                drain();
                @(posedge clk);
                #1;

                rand_ready = 1'b1;
                for (int i = 0; i < 40; i++) begin
                    r = $urandom >> $urandom_range(0, 31);
                    rb = 1'($urandom_range(0, 1));
                    apply_stimulus(r, rb, model(r, 32, 8, rb));
                end
                rand_ready = 1'b0;
                @(posedge clk);
                #1 out_ready = 1'b1;
                drain();
                @(posedge clk);
                #1;

                apply_stimulus16(16'h00F8, 1'b1, '{7, 4'hF, 1'b0, 1'b0});
                apply_stimulus16(16'h003F, 1'b1, '{6, 4'h0, 1'b0, 1'b0});
                apply_stimulus16(16'hFFFF, 1'b1, '{15, 4'hF, 1'b0, 1'b1});
                apply_stimulus16(16'hFFFF, 1'b0, '{15, 4'hF, 1'b0, 1'b0});
                for (int m = 0; m < 2; m++) begin
                    for (int v = 0; v < 65536; v += 7) begin
                        apply_stimulus16(16'(v), m[0], model(v, 16, 4, m[0]));
                    end
                    apply_stimulus16(16'hFFFF, m[0], model(65535, 16, 4, m[0]));
                end
                drain();
                done = 1'b1;
            end
            begin : monitor
                bit         stall_prev = 1'b0;
                logic [4:0] hk;
                logic [7:0] hm;
                logic       hz, hs;
                while (!done) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        stall_prev = 1'b0;
                    end else begin
                        check("in_ready", in_ready, (!(&sv)) || out_ready);
                        check("out_valid", out_valid, sv[2]);
                        if (stall_prev && out_valid) begin
                            check("hold_k", out_k, hk);
                            check("hold_m1", out_m1, hm);
                            check("hold_zero", out_zero, hz);
                            check("hold_sat", out_sat, hs);
                        end
                        check_output();
                        stall_prev = out_valid && !out_ready;
                        hk = out_k;
                        hm = out_m1;
                        hz = out_zero;
                        hs = out_sat;
                    end
                end
            end
            begin : ready_toggler
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
